// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and helpers for the RC4 key-search display scheduler.
// Holds the display mode encoding and the rotation-target search.
package rc4_disp_pkg;

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      FOUND = 2'd1,
      FAIL  = 2'd2
   } disp_mode_t;

   localparam int DEF_KEY_W = 24;

   // First index above sel (wrapping) whose done bit is clear; sel itself if none.
   function automatic logic [3:0] next_active(
      input logic [3:0]  sel,
      input logic [15:0] done_mask,
      input int          num_cores
   );
      logic [3:0] tgt;
      logic       hit;
      int         idx;
      tgt = sel;
      hit = 1'b0;
      for (int i = 1; i < 16; i++) begin
         if (i < num_cores && !hit) begin
            idx = (int'(sel) + i) % num_cores;
            if (!done_mask[idx[3:0]]) begin
               tgt = idx[3:0];
               hit = 1'b1;
            end
         end
      end
      return tgt;
   endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Core status in, display value out; the bench/cores drive master, scheduler is slave.
// Level signals only, no handshake: outputs are registered and qualified by refresh.
interface hex_display_scheduler_if #(
   parameter int NUM_CORES = 4,
   parameter int KEY_W     = rc4_disp_pkg::DEF_KEY_W
);
   import rc4_disp_pkg::*;

   localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic [NUM_CORES*KEY_W-1:0] core_key;
   logic [NUM_CORES-1:0]       core_done;
   logic [NUM_CORES-1:0]       core_found;
   logic                       hold;
   logic [KEY_W-1:0]           disp_key;
   logic [SEL_W-1:0]           disp_sel;
   disp_mode_t                 disp_mode;
   logic                       refresh;

   modport master (
      output core_key, core_done, core_found, hold,
      input  disp_key, disp_sel, disp_mode, refresh
   );

   modport slave (
      input  core_key, core_done, core_found, hold,
      output disp_key, disp_sel, disp_mode, refresh
   );

endinterface

// File: rtl/hex_display_scheduler_rate_tick_gen.sv
// Single-clock enable pulse, high for one cycle every DIV cycles; replaces divided clocks.
// The tick is a decode of the registered counter, so it leads the DIV-th edge by one cycle.
module rate_tick_gen #(
   parameter int DIV = 4
)(
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == LAST);
   assign o_tick = w_wrap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares one HEX display among the search cores: round-robin scan, sticky FOUND/FAIL.
// All outputs registered; found/fail show one cycle after the qualifying inputs.
module hex_display_scheduler #(
   parameter int NUM_CORES   = 4,
   parameter int KEY_W       = rc4_disp_pkg::DEF_KEY_W,
   parameter int REFRESH_DIV = 5_000_000,
   parameter int DWELL_TICKS = 5
)(
   input logic                    orig_clk,
   input logic                    reset_n,
   hex_display_scheduler_if.slave bus
);
   import rc4_disp_pkg::*;

   localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_TICKS - 1);

   disp_mode_t        r_state;
   logic [SEL_W-1:0]  r_sel;
   logic [KEY_W-1:0]  r_key;
   logic [DW_W-1:0]   r_dwell;
   logic              r_refresh;

   logic                 w_tick;
   logic [NUM_CORES-1:0] w_found_vec;
   logic                 w_any_found;
   logic                 w_all_done;
   logic [SEL_W-1:0]     w_found_idx;
   logic [KEY_W-1:0]     w_found_key;
   logic [KEY_W-1:0]     w_cur_key;
   logic [SEL_W-1:0]     w_next_sel;

   rate_tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
      .i_clk   (orig_clk),
      .i_rst_n (reset_n),
      .o_tick  (w_tick)
   );

   // A found bit only counts once the core also reports done.
   assign w_found_vec = bus.core_done & bus.core_found;
   assign w_any_found = |w_found_vec;
   assign w_all_done  = &bus.core_done;
   assign w_next_sel  = SEL_W'(next_active(4'(r_sel), 16'(bus.core_done), NUM_CORES));

   always_comb begin
      w_found_idx = '0;
      w_found_key = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (w_found_vec[i]) begin
            w_found_idx = SEL_W'(i);
            w_found_key = bus.core_key[i*KEY_W +: KEY_W];
         end
      end
   end

   always_comb begin
      w_cur_key = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_cur_key = bus.core_key[i*KEY_W +: KEY_W];
         end
      end
   end

   always_ff @(posedge orig_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= SCAN;
         r_sel     <= '0;
         r_key     <= '0;
         r_dwell   <= '0;
         r_refresh <= 1'b0;
      end else begin
         r_refresh <= w_tick;
         case (r_state)
            SCAN: begin
               if (w_any_found) begin
                  r_state   <= FOUND;
                  r_sel     <= w_found_idx;
                  r_key     <= w_found_key;
                  r_refresh <= 1'b1;
               end else if (w_all_done) begin
                  r_state   <= FAIL;
                  r_sel     <= '0;
                  r_key     <= '0;
                  r_refresh <= 1'b1;
               end else if (w_tick) begin
                  r_key <= w_cur_key;
                  if (!bus.hold) begin
                     if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        r_sel   <= w_next_sel;
                     end else begin
                        r_dwell <= r_dwell + 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.disp_key  = r_key;
   assign bus.disp_sel  = r_sel;
   assign bus.disp_mode = r_state;
   assign bus.refresh   = r_refresh;

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Shares the six-digit HEX display between the parallel RC4 key-search cores. While searching, it rotates round-robin through the cores' current candidate keys. When any core reports a verified key, it locks onto that key. When every core has finished without success, it shows a failure indication. Its outputs feed the seven-segment decoder stage, and a single-clock enable tick replaces the divided display clock.

## Interface
Parameters:
- NUM_CORES, 4, number of search cores sharing the display (2..16)
- KEY_W, 24, candidate key width (six hex digits)
- REFRESH_DIV, 5_000_000, orig_clk cycles per display refresh tick (10 Hz at 50 MHz)
- DWELL_TICKS, 5, refresh ticks each core is shown before rotating

Ports:
- orig_clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- core_key  in  NUM_CORES×KEY_W  current candidate key of each core
- core_done  in  NUM_CORES  level; core has finished its key range or found a key
- core_found  in  NUM_CORES  level; qualified by core_done; key verified
- hold  in  1  freezes rotation (slide switch, already synchronised)
- disp_key  out  KEY_W  value for the digit decoders
- disp_sel  out  $clog2(NUM_CORES)  index of the core being shown
- disp_mode  out  2  SCAN=0, FOUND=1, FAIL=2
- refresh  out  1  one-cycle pulse when disp_key/disp_sel update

## Operation
- Free-running refresh counter: 0..REFRESH_DIV-1. refresh=1 in the cycle the counter wraps.
- FSM states:
  - SCAN (reset state)
  - FOUND (sticky until reset)
  - FAIL (sticky until reset)
- SCAN behaviour:
  - On each refresh: disp_key ← core_key[disp_sel] (sampled that cycle).
  - Unless hold=1, a dwell counter increments on each refresh.
  - When the dwell counter reaches DWELL_TICKS-1 on a refresh: dwell counter→0 and disp_sel advances.
  - Advance target: the next index above disp_sel, wrapping, with core_done=0. If no other index qualifies, disp_sel is unchanged.
- SCAN→FOUND: in any cycle where |(core_done & core_found).
  - Latch the lowest such index into disp_sel and its core_key into disp_key on the next edge, without waiting for a refresh tick.
  - refresh is forced high in that cycle.
- SCAN→FAIL: &core_done and no found bit set.
  - disp_key←0 and disp_sel←0 on the next edge; refresh forced.
- FOUND and all-done in the same cycle → FOUND wins.
- In FOUND and FAIL, disp_key and disp_sel are frozen. Refresh ticks still pulse; inputs are ignored.
- hold does not affect the FOUND/FAIL transitions.

## Timing
- Reset values: disp_key=0, disp_sel=0, disp_mode=SCAN, refresh=0, both counters=0.
- Reset is asynchronous assert, synchronous release, and may occur mid-dwell or in any state. Everything returns to the reset values.
- All outputs are registered.
- First refresh: REFRESH_DIV cycles after reset release.
- Rotation period: DWELL_TICKS×REFRESH_DIV cycles per core.
- Found/fail latency: 1 cycle from the qualifying input to the output change.
- core_found while core_done=0 is ignored.
- Counter widths: $clog2(REFRESH_DIV) and $clog2(DWELL_TICKS). No overflow beyond the terminal value.

## Structure
- Package rc4_disp_pkg:
  - disp_mode_t enum (SCAN, FOUND, FAIL)
  - KEY_W default
  - helper function next_active(sel, done_mask) returning the rotation target
- Sub-module rate_tick_gen (parameter DIV): single-clock enable pulse generator with async active-low reset. Used for refresh; reusable across the design instead of divided clocks.
- The FSM, dwell counter and selection/latch logic stay in hex_display_scheduler.

## Test plan
Bench settings: NUM_CORES=4, REFRESH_DIV=4, DWELL_TICKS=2.
- Reset, no done bits, keys 0x111111/0x222222/0x333333/0x444444:
  - refresh every 4 cycles
  - disp_sel sequence 0,0,1,1,2,2,3,3,0
  - disp_key tracks each core with one refresh of latency
- core_done=4'b0101, none found: rotation visits only cores 1 and 3.
- hold=1 during SCAN: disp_sel frozen for 20 cycles; disp_key still refreshes from the selected core. On release, rotation resumes.
- Cores 2 and 3 assert done+found in the same cycle with keys 0xABCDEF/0x123456:
  - next cycle: disp_mode=FOUND, disp_sel=2, disp_key=0xABCDEF, refresh=1
  - held through later key changes
- core_done=4'b1111, found=0:
  - next cycle: disp_mode=FAIL, disp_key=0
  - same stimulus with found[0]=1 gives FOUND instead
- reset_n pulsed low mid-dwell and in FOUND: outputs go to reset values immediately, and the rotation restarts at core 0.
